// File: rtl/pedal_pkg.sv
// Shared types and helpers for the pedal chain's converter front ends.
// Sample width, midscale code and signed-to-offset-binary mapping live here.
package pedal_pkg;

  localparam int SAMPLE_W = 8;

  localparam logic [SAMPLE_W-1:0] MIDSCALE = {1'b1, {(SAMPLE_W-1){1'b0}}};

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    logic ovr;
    logic udr;
  } dac_flags_t;

  // Flipping the MSB is the same as adding half scale modulo 2^N.
  function automatic sample_t to_offset_bin(input logic signed [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/pwm_dac_out_if.sv
// Signed sample stream from the effect modules into the DAC output stage.
// One-cycle vld strobe per sample; the sink never stalls the source.
interface pwm_dac_out_if #(
  parameter int DATA_WIDTH = pedal_pkg::SAMPLE_W
);
  logic [DATA_WIDTH-1:0] data_i;
  logic                  vld_i;

  modport master (output data_i, output vld_i);
  modport slave  (input  data_i, input  vld_i);
endinterface

// File: rtl/pwm_dac_out_tick_gen.sv
// PWM tick prescaler: tick is high on the last clock of every CLK_DIV group.
// Held at zero while en is low so a re-enabled engine restarts on a clean tick.
module tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int            PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (!en) begin
      pre_d = '0;
    end else if (pre_q == LAST) begin
      pre_d = '0;
      tick  = 1'b1;
    end else begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

endmodule

// File: rtl/pwm_dac_out.sv
// Sample stream to single-bit PWM for the RC-filtered audio DAC; new duty lands one cycle
// after the period boundary, pwm_o follows a cycle later. No backpressure: ovr/udr report rate slip.
module pwm_dac_out #(
  parameter int DATA_WIDTH = pedal_pkg::SAMPLE_W,
  parameter int CLK_DIV    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  pwm_dac_out_if.slave s_if,
  output logic         pwm_o,
  output logic         frame_o,
  output logic         ovr_o,
  output logic         udr_o
);

  import pedal_pkg::*;

  localparam int N = DATA_WIDTH;
  localparam logic [N-1:0] CNT_LAST = '1;

  logic [N-1:0] mid;
  logic [N-1:0] u;

  generate
    if (N == SAMPLE_W) begin : g_pkg_conv
      assign mid = MIDSCALE;
      assign u   = to_offset_bin($signed(s_if.data_i));
    end else begin : g_local_conv
      assign mid = {1'b1, {(N-1){1'b0}}};
      assign u   = {~s_if.data_i[N-1], s_if.data_i[N-2:0]};
    end
  endgenerate

  logic tick;
  logic bnd;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  logic [N-1:0] cnt_q,  cnt_d;
  logic [N-1:0] duty_q, duty_d;
  logic [N-1:0] pend_q, pend_d;
  logic         pend_vld_q, pend_vld_d;
  logic         armed_q,    armed_d;
  logic         pwm_q,      pwm_d;
  logic         frame_q,    frame_d;
  dac_flags_t   flg_q,      flg_d;

  assign bnd = tick && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d      = cnt_q;
    duty_d     = duty_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    armed_d    = armed_q;
    pwm_d      = 1'b0;
    frame_d    = 1'b0;
    flg_d      = flg_q;

    if (clr) flg_d = '0;

    if (!en) begin
      cnt_d      = '0;
      duty_d     = mid;
      pend_vld_d = 1'b0;
      armed_d    = 1'b0;
    end else begin
      pwm_d   = (cnt_q < duty_q);
      frame_d = bnd;
      if (tick) cnt_d = cnt_q + 1'b1;

      if (bnd) begin
        if (pend_vld_q) begin
          duty_d     = pend_q;
          pend_vld_d = 1'b0;
          armed_d    = 1'b1;
        end else if (armed_q) begin
          flg_d.udr = 1'b1;
        end
      end

      // A sample arriving on the boundary replaces a buffer that is being drained, not lost.
      if (s_if.vld_i) begin
        if (pend_vld_q && !bnd) flg_d.ovr = 1'b1;
        pend_d     = u;
        pend_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      duty_q     <= mid;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      armed_q    <= 1'b0;
      pwm_q      <= 1'b0;
      frame_q    <= 1'b0;
      flg_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      duty_q     <= duty_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      armed_q    <= armed_d;
      pwm_q      <= pwm_d;
      frame_q    <= frame_d;
      flg_q      <= flg_d;
    end
  end

  assign pwm_o   = pwm_q;
  assign frame_o = frame_q;
  assign ovr_o   = flg_q.ovr;
  assign udr_o   = flg_q.udr;

endmodule

// File: tb/tb_pwm_dac_out.sv
// Bench for pwm_dac_out: scheduled and random sample streams scored per PWM period
// against a window-based model of which sample each boundary consumes.
module tb_pwm_dac_out;

  localparam int N    = 8;
  localparam int PER  = 256;
  localparam int MAXP = 8;
  localparam int MAXE = PER * MAXP + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic en4 = 1'b0;
  logic clr = 1'b0;
  logic pwm_o, frame_o, ovr_o, udr_o;
  logic pwm4, frm4, ovr4, udr4;

  int errors = 0;
  int checks = 0;

  pwm_dac_out_if #(.DATA_WIDTH(N)) sif ();
  pwm_dac_out_if #(.DATA_WIDTH(N)) sif4 ();

  pwm_dac_out #(.DATA_WIDTH(N), .CLK_DIV(1)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .s_if(sif),
    .pwm_o(pwm_o), .frame_o(frame_o), .ovr_o(ovr_o), .udr_o(udr_o)
  );

  pwm_dac_out #(.DATA_WIDTH(N), .CLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .clr(1'b0), .s_if(sif4),
    .pwm_o(pwm4), .frame_o(frm4), .ovr_o(ovr4), .udr_o(udr4)
  );

  always #5 clk = ~clk;

  // Per-edge schedule (index = posedge number since en rose) and observed history.
  logic       s_vld [MAXE];
  logic [7:0] s_dat [MAXE];
  logic       s_clr [MAXE];
  logic       h_pwm [MAXE];
  logic       h_frm [MAXE];
  logic       h_ovr [MAXE];
  logic       h_udr [MAXE];
  logic       m_so  [MAXE];
  logic       m_su  [MAXE];
  int         m_duty [MAXP+1];
  logic       ovr0, udr0;

  task automatic clear_sched();
    for (int i = 0; i < MAXE; i++) begin
      s_vld[i] = 1'b0; s_dat[i] = 8'h00; s_clr[i] = 1'b0;
    end
    ovr0 = 1'b0;
    udr0 = 1'b0;
  endtask

  task automatic add_sample(input int x, input logic [7:0] d);
    s_vld[x] = 1'b1;
    s_dat[x] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; en4 = 1'b0; clr = 1'b0;
    sif.vld_i = 1'b0; sif.data_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_edges(input int n);
    for (int x = 1; x <= n; x++) begin
      en = 1'b1;
      sif.vld_i  = s_vld[x];
      sif.data_i = s_dat[x];
      clr        = s_clr[x];
      @(negedge clk);
      h_pwm[x] = pwm_o; h_frm[x] = frame_o; h_ovr[x] = ovr_o; h_udr[x] = udr_o;
    end
    sif.vld_i = 1'b0;
    clr       = 1'b0;
  endtask

  function automatic int hi_count(input int p);
    int c;
    c = 0;
    for (int k = 1; k <= PER; k++) if (h_pwm[PER*p + k] === 1'b1) c++;
    return c;
  endfunction

  // Boundary p consumes the last sample seen on edges PER*(p-1) .. PER*p-1.
  task automatic check_model(input int P, input string tag);
    logic armed, fo, fu, ep, ef, ao, au;
    int   ns, last, x, hi, bad_p, bad_f, bad_o, bad_u;
    for (int i = 0; i < MAXE; i++) begin m_so[i] = 1'b0; m_su[i] = 1'b0; end
    armed = 1'b0;
    m_duty[0] = 128;
    for (int p = 1; p <= P; p++) begin
      ns = 0; last = 0;
      for (int ed = PER*(p-1); ed < PER*p; ed++) begin
        if (ed >= 1 && s_vld[ed]) begin
          ns++;
          last = int'($signed(s_dat[ed])) + 128;
          if (ns >= 2) m_so[ed] = 1'b1;
        end
      end
      if (ns > 0) begin
        m_duty[p] = last;
        armed = 1'b1;
      end else begin
        m_duty[p] = m_duty[p-1];
        if (armed) m_su[PER*p] = 1'b1;
      end
    end

    fo = ovr0; fu = udr0;
    for (int p = 0; p < P; p++) begin
      hi = 0; bad_p = -1; bad_f = -1; bad_o = -1; bad_u = -1; ao = 1'b0; au = 1'b0;
      for (int k = 1; k <= PER; k++) begin
        x  = PER*p + k;
        ep = ((k - 1) < m_duty[p]);
        ef = (k == PER);
        if (m_so[x]) fo = 1'b1; else if (s_clr[x]) fo = 1'b0;
        if (m_su[x]) fu = 1'b1; else if (s_clr[x]) fu = 1'b0;
        if (h_pwm[x] === 1'b1) hi++;
        if (h_pwm[x] !== ep && bad_p < 0) bad_p = x;
        if (h_frm[x] !== ef && bad_f < 0) bad_f = x;
        if (h_ovr[x] !== fo && bad_o < 0) begin bad_o = x; ao = fo; end
        if (h_udr[x] !== fu && bad_u < 0) begin bad_u = x; au = fu; end
      end
      checks += 4;
      if (bad_p >= 0) begin
        errors++;
        $display("FAIL %s pwm period %0d: got %0d high cycles (first wrong edge %0d), required duty %0d",
                 tag, p, hi, bad_p, m_duty[p]);
      end
      if (bad_f >= 0) begin
        errors++;
        $display("FAIL %s frame period %0d: got frame_o=%b at edge %0d, required %b",
                 tag, p, h_frm[bad_f], bad_f, (bad_f % PER) == 0);
      end
      if (bad_o >= 0) begin
        errors++;
        $display("FAIL %s ovr period %0d: got %b at edge %0d, required %b", tag, p, h_ovr[bad_o], bad_o, ao);
      end
      if (bad_u >= 0) begin
        errors++;
        $display("FAIL %s udr period %0d: got %b at edge %0d, required %b", tag, p, h_udr[bad_u], bad_u, au);
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (pwm_o !== 1'b0)   begin errors++; $display("FAIL reset pwm_o: got %b, required 0", pwm_o); end
    if (frame_o !== 1'b0) begin errors++; $display("FAIL reset frame_o: got %b, required 0", frame_o); end
    if (ovr_o !== 1'b0)   begin errors++; $display("FAIL reset ovr_o: got %b, required 0", ovr_o); end
    if (udr_o !== 1'b0)   begin errors++; $display("FAIL reset udr_o: got %b, required 0", udr_o); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_idle();
    do_reset(); clear_sched();
    run_edges(3*PER);
    check_model(3, "idle");
    checks++;
    if (hi_count(2) !== 128) begin errors++; $display("FAIL idle midscale: got %0d high, required 128", hi_count(2)); end
  endtask

  task automatic test_full_scale();
    do_reset(); clear_sched();
    add_sample(10, 8'h7F);
    add_sample(PER + 10, 8'h80);
    run_edges(3*PER);
    check_model(3, "fullscale");
    checks += 2;
    if (hi_count(1) !== 255) begin errors++; $display("FAIL fullscale 0x7F: got %0d high, required 255", hi_count(1)); end
    if (hi_count(2) !== 0)   begin errors++; $display("FAIL fullscale 0x80: got %0d high, required 0", hi_count(2)); end
  endtask

  task automatic test_overrun();
    do_reset(); clear_sched();
    add_sample(20, 8'h10);
    add_sample(100, 8'h20);
    s_clr[300] = 1'b1;
    run_edges(2*PER);
    check_model(2, "overrun");
    checks += 4;
    if (h_ovr[99] !== 1'b0)  begin errors++; $display("FAIL overrun early: got ovr=%b, required 0", h_ovr[99]); end
    if (h_ovr[100] !== 1'b1) begin errors++; $display("FAIL overrun set: got ovr=%b, required 1", h_ovr[100]); end
    if (hi_count(1) !== 160) begin errors++; $display("FAIL overrun duty: got %0d high, required 160", hi_count(1)); end
    if (h_ovr[300] !== 1'b0) begin errors++; $display("FAIL overrun clr: got ovr=%b, required 0", h_ovr[300]); end
  endtask

  task automatic test_underrun();
    do_reset(); clear_sched();
    add_sample(50, 8'h40);
    s_clr[700] = 1'b1;
    s_clr[768] = 1'b1;
    run_edges(3*PER);
    check_model(3, "underrun");
    checks += 5;
    if (h_udr[511] !== 1'b0) begin errors++; $display("FAIL underrun early: got udr=%b, required 0", h_udr[511]); end
    if (h_udr[512] !== 1'b1) begin errors++; $display("FAIL underrun set: got udr=%b, required 1", h_udr[512]); end
    if (hi_count(2) !== 192) begin errors++; $display("FAIL underrun repeat: got %0d high, required 192", hi_count(2)); end
    if (h_udr[700] !== 1'b0) begin errors++; $display("FAIL underrun clr: got udr=%b, required 0", h_udr[700]); end
    if (h_udr[768] !== 1'b1) begin errors++; $display("FAIL underrun set-wins: got udr=%b, required 1", h_udr[768]); end
  endtask

  task automatic test_coincidence();
    do_reset(); clear_sched();
    add_sample(100, 8'h30);
    add_sample(PER, 8'h50);
    run_edges(3*PER);
    check_model(3, "coincide");
    checks += 3;
    if (h_ovr[3*PER] !== 1'b0) begin errors++; $display("FAIL coincide ovr: got %b, required 0", h_ovr[3*PER]); end
    if (hi_count(1) !== 176)   begin errors++; $display("FAIL coincide first: got %0d high, required 176", hi_count(1)); end
    if (hi_count(2) !== 208)   begin errors++; $display("FAIL coincide second: got %0d high, required 208", hi_count(2)); end
  endtask

  task automatic test_random();
    int n, x;
    for (int it = 0; it < 3; it++) begin
      do_reset(); clear_sched();
      for (int s = 0; s < 6; s++) begin
        n = $urandom_range(3);
        for (int j = 0; j < n; j++) begin
          if (s > 0 && $urandom_range(3) == 0) x = PER*s;
          else x = PER*s + $urandom_range(PER-1);
          if (x < 1) x = 1;
          add_sample(x, 8'($urandom));
        end
      end
      for (int j = 0; j < 2; j++) s_clr[$urandom_range(PER*6, 1)] = 1'b1;
      run_edges(6*PER);
      check_model(6, "random");
    end
  endtask

  task automatic test_disable();
    do_reset(); clear_sched();
    add_sample(10, 8'h10);
    add_sample(20, 8'h20);
    run_edges(60);
    checks += 2;
    if (h_pwm[60] !== 1'b1) begin errors++; $display("FAIL disable pre pwm: got %b, required 1", h_pwm[60]); end
    if (h_ovr[60] !== 1'b1) begin errors++; $display("FAIL disable pre ovr: got %b, required 1", h_ovr[60]); end
    en = 1'b0; sif.vld_i = 1'b1; sif.data_i = 8'h7F;
    @(negedge clk);
    checks += 3;
    if (pwm_o !== 1'b0)   begin errors++; $display("FAIL disable pwm: got %b, required 0", pwm_o); end
    if (frame_o !== 1'b0) begin errors++; $display("FAIL disable frame: got %b, required 0", frame_o); end
    if (ovr_o !== 1'b1)   begin errors++; $display("FAIL disable ovr hold: got %b, required 1", ovr_o); end
    repeat (3) @(negedge clk);
    sif.vld_i = 1'b0;
    clear_sched();
    ovr0 = 1'b1;
    run_edges(2*PER);
    check_model(2, "reenable");
  endtask

  task automatic test_clkdiv();
    int k1, k2, hi;
    do_reset();
    en4 = 1'b1;
    k1 = -1; k2 = -1; hi = 0;
    for (int k = 1; k <= 3000 && k2 < 0; k++) begin
      @(negedge clk);
      if (k1 >= 0 && pwm4 === 1'b1) hi++;
      if (frm4 === 1'b1) begin
        if (k1 < 0) k1 = k; else k2 = k;
      end
    end
    en4 = 1'b0;
    checks += 5;
    if (k1 !== 1024)     begin errors++; $display("FAIL div4 first frame: got edge %0d, required 1024", k1); end
    if (k2 - k1 !== 1024) begin errors++; $display("FAIL div4 period: got %0d cycles, required 1024", k2 - k1); end
    if (hi !== 512)      begin errors++; $display("FAIL div4 high: got %0d cycles, required 512", hi); end
    if (ovr4 !== 1'b0)   begin errors++; $display("FAIL div4 ovr: got %b, required 0", ovr4); end
    if (udr4 !== 1'b0)   begin errors++; $display("FAIL div4 udr: got %b, required 0", udr4); end
  endtask

  task automatic test_async_reset();
    do_reset(); clear_sched();
    add_sample(10, 8'h10);
    add_sample(20, 8'h20);
    run_edges(60);
    checks++;
    if (pwm_o !== 1'b1) begin errors++; $display("FAIL arst pre pwm: got %b, required 1", pwm_o); end
    #1 rst = 1'b1;
    #1;
    checks += 2;
    if (pwm_o !== 1'b0) begin errors++; $display("FAIL arst pwm: got %b, required 0", pwm_o); end
    if (ovr_o !== 1'b0) begin errors++; $display("FAIL arst ovr: got %b, required 0", ovr_o); end
    @(negedge clk);
    rst = 1'b0;
    do_reset(); clear_sched();
    run_edges(PER);
    checks++;
    if (frame_o !== 1'b1) begin errors++; $display("FAIL arst pre frame: got %b, required 1", frame_o); end
    #1 rst = 1'b1;
    #1;
    checks += 2;
    if (frame_o !== 1'b0) begin errors++; $display("FAIL arst frame: got %b, required 0", frame_o); end
    if (pwm_o !== 1'b0)   begin errors++; $display("FAIL arst pwm2: got %b, required 0", pwm_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    sif.vld_i = 1'b0; sif.data_i = '0;
    sif4.vld_i = 1'b0; sif4.data_i = '0;
    clear_sched();
    test_reset();
    test_idle();
    test_full_scale();
    test_overrun();
    test_underrun();
    test_coincidence();
    test_random();
    test_disable();
    test_clkdiv();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_dac_out.md
# pwm_dac_out

Output stage of the pedal effect chain that sits directly downstream of the effect modules. It takes their signed `data_o`/`vld_o` sample stream and converts each sample to offset binary. Each sample is held in a one-deep pending buffer and loaded at a PWM period boundary, and the block drives a single-bit PWM output for the board's RC-filtered audio DAC. Sticky overrun and underrun flags report rate mismatch between the effect stream and the PWM frame rate.

## Interface
- `DATA_WIDTH`, 8: sample width (N); PWM period is 2^N ticks.
- `CLK_DIV`, 1: clocks per PWM tick, ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  output enable; 0 mutes and holds the PWM engine idle.
- `data_i`  in  DATA_WIDTH  signed two's-complement sample.
- `vld_i`  in  1  sample strobe, one cycle per sample. There is no backpressure.
- `clr`  in  1  synchronous clear of the sticky flags.
- `pwm_o`  out  1  registered PWM output.
- `frame_o`  out  1  one-cycle pulse at the start of each PWM period.
- `ovr_o`  out  1  sticky: a pending sample was overwritten before it was consumed.
- `udr_o`  out  1  sticky: a period boundary occurred with no pending sample, after the block is armed.

## Operation
- **Conversion:** u = data_i with its MSB inverted, which equals data_i + 2^(N-1) mod 2^N.
- **Pending buffer (pend, pend_vld):**
  - When `vld_i` is high, pend <= u and pend_vld <= 1.
  - If pend_vld is already 1 and the buffer is not being consumed that cycle, the old value is overwritten and ovr is set.
- **Tick prescaler:** counts 0..CLK_DIV-1. `tick` is high when the prescaler is at CLK_DIV-1; with CLK_DIV=1, `tick` is always high.
- **PWM counter:** `cnt` is N bits, increments on `tick`, and wraps from 2^N-1 to 0.
- **Boundary event B:** `tick` && cnt==2^N-1. On B:
  - If pend_vld is 1: duty <= pend, pend_vld <= 0, and the block becomes armed.
  - If pend_vld is 0: duty is held, and udr is set if armed.
- **B and `vld_i` in the same cycle:** the old pend is consumed into duty and the new sample lands in pend with pend_vld=1. No ovr is set.
- **Output compare:** pwm_o <= en && (cnt < duty).
  - duty=0 gives a constant low.
  - duty=2^N-1 gives high for 2^N-1 of 2^N ticks.
- **Flags:** `clr` clears ovr and udr. If a set event occurs in the same cycle as `clr`, the set wins.
- **en=0:**
  - prescaler, cnt and armed are cleared; pend_vld is cleared.
  - duty returns to 2^(N-1); pwm_o and frame_o are 0.
  - Flags hold their value and samples are dropped without setting ovr.
  - When en rises, the first period starts with cnt=0.

## Timing
- **Reset values:**
  - Outputs: pwm_o=0, frame_o=0, ovr_o=0, udr_o=0.
  - Internal: duty=2^(N-1), cnt=0, prescaler=0, pend_vld=0, armed=0.
- All outputs are cleared asynchronously on rst assertion, mid-period included, with no clock edge required.
- **Boundary timing:** if B occurs at cycle t:
  - At t+1, cnt=0, the new duty is in place and frame_o=1 for one cycle.
  - At t+2, pwm_o first reflects the new duty.
- **Sample latency:** from `vld_i` to the first affected `pwm_o` bit is between 2 cycles and 2^N·CLK_DIV+1 cycles, depending on where the sample lands in the period.
- **Sample rate:** the sustained accepted rate is one sample per 2^N·CLK_DIV clocks. A faster stream raises ovr and a slower one raises udr.

## Structure
- **Shared package `pedal_pkg`:**
  - function `to_offset_bin(logic signed [N-1:0])`
  - localparam `MIDSCALE` = 2^(N-1)
  - these are reused by any future DAC or ADC front end.
- **Sub-module `tick_gen`:** parameter CLK_DIV; ports clk, rst, en, tick. This is the prescaler.
- Everything else stays in `pwm_dac_out`: pending buffer, counter, compare, and flags.

## Test plan
All scenarios use N=8 and CLK_DIV=1 (period 256 cycles) unless stated otherwise.
- **Reset then en=1, no samples:** pwm_o is high 128 of each 256 cycles, frame_o pulses every 256 cycles, and udr_o stays 0 because the block is not armed.
- **Full-scale samples:** one `vld_i` with data_i=0x7F, then a period later data_i=0x80. The result is one period high 255/256 (duty 0xFF), followed by one period constantly low (duty 0x00).
- **Overrun:** two samples, 0x10 then 0x20, inside one period. ovr_o=1, and the next period has duty 0xA0, i.e. high for 160 cycles. Asserting clr alone then gives ovr_o=0.
- **Underrun:** after arming with 0x40 (duty 0xC0), skip one period. udr_o=1 and the period repeats 192 high cycles. Then `clr` in the same cycle as the next underrun boundary leaves udr_o=1.
- **Boundary coincidence:** `vld_i` on the exact B cycle while a sample is pending gives no ovr. The pending value drives the next period and the new sample drives the one after.
- **Disable and reset:**
  - en=0 mid-period forces pwm_o=0 within one cycle.
  - With CLK_DIV=4, the period measures 1024 cycles.
  - An async rst pulse between clock edges forces pwm_o=0 and frame_o=0 before the next edge.
